// File: rtl/bus_pkg.sv
// Shared constants for the datapath bus: default sizes, source indices and arbitration modes.
package bus_pkg;

    localparam int NSRC_DEF  = 24;
    localparam int WIDTH_DEF = 32;

    localparam int R0     = 0;
    localparam int R1     = 1;
    localparam int R2     = 2;
    localparam int R3     = 3;
    localparam int R4     = 4;
    localparam int R5     = 5;
    localparam int R6     = 6;
    localparam int R7     = 7;
    localparam int R8     = 8;
    localparam int R9     = 9;
    localparam int R10    = 10;
    localparam int R11    = 11;
    localparam int R12    = 12;
    localparam int R13    = 13;
    localparam int R14    = 14;
    localparam int R15    = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int C      = 23;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/bus_rr_encoder.sv
// Combinational rotating priority encoder: first set request at or after start, wrapping.
// A start of zero degenerates to plain lowest-index priority.
module bus_rr_encoder #(
    parameter int NSRC = 24,
    parameter int SELW = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] grant_idx,
    output logic            found,
    output logic            multi
);

    logic [NSRC-1:0] rot_req;
    logic [SELW-1:0] offset;
    logic [SELW:0]   sum;
    logic            seen;

    // Rotate right by start so bit 0 of rot_req is the request at index start.
    assign rot_req = NSRC'({req, req} >> start);

    always_comb begin
        offset    = '0;
        sum       = '0;
        grant_idx = '0;
        found     = |req;
        multi     = 1'b0;
        seen      = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = SELW'(k);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= (SELW + 1)'(NSRC)) begin
            sum = sum - (SELW + 1)'(NSRC);
        end
        grant_idx = sum[SELW-1:0];
        for (int i = 0; i < NSRC; i++) begin
            multi = multi | (seen & req[i]);
            seen  = seen | req[i];
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered bus source selector with fixed-priority or round-robin arbitration
// and multiple-driver conflict detection/counting.
module bus_arb_mux
    import bus_pkg::*;
#(
    parameter int NSRC     = NSRC_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int SELW     = $clog2(NSRC)
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [NSRC-1:0]         src_out,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_valid,
    output logic [SELW-1:0]         sel_code,
    output logic                    conflict,
    output logic                    conflict_sticky,
    output logic [7:0]              conflict_count
);

    logic [WIDTH-1:0] words [NSRC];

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_words
            assign words[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [SELW-1:0]  grant_idx;
    logic             grant_found;
    logic             multi_req;
    logic [SELW-1:0]  enc_start;

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             conflict_q, conflict_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       count_q, count_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    // Fixed priority is the rotating encoder pinned to start 0.
    assign enc_start = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    bus_rr_encoder #(
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_enc (
        .req       (src_out),
        .start     (enc_start),
        .grant_idx (grant_idx),
        .found     (grant_found),
        .multi     (multi_req)
    );

    always_comb begin
        bus_d      = bus_q;
        valid_d    = 1'b0;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        conflict_d = multi_req;
        sticky_d   = sticky_q;
        count_d    = count_q;

        if (grant_found) begin
            bus_d   = words[grant_idx];
            valid_d = 1'b1;
            sel_d   = grant_idx;
            if (ARB_MODE == ARB_RR) begin
                rr_ptr_d = (grant_idx == SELW'(NSRC - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end

        // A conflict coincident with err_clr is recorded after the clear.
        if (err_clr) begin
            sticky_d = 1'b0;
            count_d  = 8'd0;
        end
        if (multi_req) begin
            sticky_d = 1'b1;
            if (err_clr) begin
                count_d = 8'd1;
            end else if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            sel_q      <= '0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= 8'd0;
            rr_ptr_q   <= '0;
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus_out         = bus_q;
    assign bus_valid       = valid_q;
    assign sel_code        = sel_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_count  = count_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: one fixed-priority and one round-robin instance on shared inputs.
module tb_bus_arb_mux;

    localparam int NSRC  = 24;
    localparam int WIDTH = 32;

    logic                  clock = 1'b0;
    logic                  clear = 1'b1;
    logic [NSRC-1:0]       src_out = '0;
    logic [NSRC*WIDTH-1:0] src_data = '0;
    logic                  err_clr = 1'b0;

    logic [WIDTH-1:0] f_bus, r_bus;
    logic             f_valid, r_valid;
    logic [4:0]       f_sel, r_sel;
    logic             f_conf, r_conf;
    logic             f_sticky, r_sticky;
    logic [7:0]       f_count, r_count;

    int passed = 0;
    int total  = 0;

    bus_arb_mux #(.NSRC(NSRC), .WIDTH(WIDTH), .ARB_MODE(0)) u_fix (
        .clock(clock), .clear(clear), .src_out(src_out), .src_data(src_data),
        .err_clr(err_clr), .bus_out(f_bus), .bus_valid(f_valid), .sel_code(f_sel),
        .conflict(f_conf), .conflict_sticky(f_sticky), .conflict_count(f_count)
    );

    bus_arb_mux #(.NSRC(NSRC), .WIDTH(WIDTH), .ARB_MODE(1)) u_rr (
        .clock(clock), .clear(clear), .src_out(src_out), .src_data(src_data),
        .err_clr(err_clr), .bus_out(r_bus), .bus_valid(r_valid), .sel_code(r_sel),
        .conflict(r_conf), .conflict_sticky(r_sticky), .conflict_count(r_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        src_data[idx*WIDTH +: WIDTH] = w;
    endtask

    initial begin
        int rr_exp [6];
        rr_exp = '{1, 5, 23, 1, 5, 23};

        for (int i = 0; i < NSRC; i++) set_word(i, 32'h100 + i);
        set_word(0, 32'hDEADBEEF);
        set_word(20, 32'h0000_1234);
        set_word(21, 32'hA5A5_A5A5);

        // Reset state
        #12;
        chk("reset_bus", f_bus, 32'h0);
        chk("reset_valid", 32'(f_valid), 32'd0);
        chk("reset_count", 32'(f_count), 32'd0);
        clear = 1'b0;

        // Single source PC
        src_out = 24'(1) << 20;
        tick();
        chk("pc_bus", f_bus, 32'h0000_1234);
        chk("pc_sel", 32'(f_sel), 32'd20);
        chk("pc_valid", 32'(f_valid), 32'd1);
        chk("pc_conflict", 32'(f_conf), 32'd0);
        chk("pc_rr_bus", r_bus, 32'h0000_1234);
        $display("txn pc: bus=%h sel=%0d", f_bus, f_sel);

        // MDR then three idle cycles: bus holds
        src_out = 24'(1) << 21;
        tick();
        src_out = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_bus", f_bus, 32'hA5A5_A5A5);
            chk("hold_valid", 32'(f_valid), 32'd0);
            chk("hold_sel", 32'(f_sel), 32'd21);
            $display("txn hold %0d: bus=%h valid=%0d", c, f_bus, f_valid);
        end

        // Asynchronous clear mid-stream
        src_out = 24'd1;
        tick();
        chk("deadbeef_bus", f_bus, 32'hDEADBEEF);
        src_out = '0;
        clear = 1'b1;
        #1;
        chk("aclr_bus", f_bus, 32'h0);
        chk("aclr_sel", 32'(f_sel), 32'd0);
        chk("aclr_valid", 32'(f_valid), 32'd0);
        #2;
        clear = 1'b0;
        tick();
        chk("post_clr_bus", f_bus, 32'h0);
        chk("post_clr_valid", 32'(f_valid), 32'd0);
        $display("txn async clear: bus=%h", f_bus);

        // Fixed-priority conflict R3 vs HI
        src_out = (24'(1) << 3) | (24'(1) << 16);
        tick();
        chk("conf_bus", f_bus, 32'h103);
        chk("conf_sel", 32'(f_sel), 32'd3);
        chk("conf_flag", 32'(f_conf), 32'd1);
        chk("conf_sticky", 32'(f_sticky), 32'd1);
        chk("conf_count1", 32'(f_count), 32'd1);
        tick();
        chk("conf_count2", 32'(f_count), 32'd2);
        for (int c = 0; c < 298; c++) @(posedge clock);
        #1;
        chk("conf_sat", 32'(f_count), 32'd255);
        chk("conf_sat_rr", 32'(r_count), 32'd255);
        $display("txn saturate: count=%0d", f_count);

        // err_clr with no conflict
        src_out = '0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_sticky", 32'(f_sticky), 32'd0);
        chk("clr_count", 32'(f_count), 32'd0);
        chk("clr_conflict", 32'(f_conf), 32'd0);
        $display("txn err_clr: sticky=%0d count=%0d", f_sticky, f_count);

        // err_clr coincident with a conflict
        src_out = (24'(1) << 3) | (24'(1) << 16);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        src_out = '0;
        chk("coinc_sticky", 32'(f_sticky), 32'd1);
        chk("coinc_count", 32'(f_count), 32'd1);
        chk("coinc_flag", 32'(f_conf), 32'd1);
        $display("txn err_clr+conflict: sticky=%0d count=%0d", f_sticky, f_count);

        // Round-robin from pointer 0: R1, R5, C, wrapping back to R1
        clear = 1'b1;
        #2;
        clear = 1'b0;
        src_out = (24'(1) << 1) | (24'(1) << 5) | (24'(1) << 23);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rr_sel", 32'(r_sel), 32'(rr_exp[c]));
            chk("rr_bus", r_bus, 32'h100 + 32'(rr_exp[c]));
            chk("rr_fix_sel", 32'(f_sel), 32'd1);
            $display("txn rr %0d: sel=%0d bus=%h", c, r_sel, r_bus);
        end
        chk("rr_count", 32'(r_count), 32'd6);
        src_out = '0;
        tick();
        chk("rr_idle_valid", 32'(r_valid), 32'd0);
        chk("rr_idle_conf", 32'(r_conf), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
